// File: rtl/trackball_pkg.sv
// Shared constants, types and helpers for the PS/2-mouse to quadrature trackball bridge.
package trackball_pkg;

    localparam int ACC_W_DEF = 12;

    // Bit positions inside the hps_io ps2_mouse word
    localparam int TOG    = 24;
    localparam int DY_MSB = 23;
    localparam int DX_MSB = 15;
    localparam int YS     = 5;
    localparam int XS     = 4;

    typedef logic signed [ACC_W_DEF-1:0] acc_t;

    // Symmetric clamp to [-limit, +limit]
    function automatic int sat(input int value, input int limit);
        int result;
        result = value;
        if (value > limit) begin
            result = limit;
        end else if (value < -limit) begin
            result = -limit;
        end
        return result;
    endfunction

    // One joystick count for an opposing pair: +1, -1, or 0 when both or neither are held
    function automatic logic signed [1:0] joy_step(input logic pos, input logic neg);
        logic signed [1:0] step;
        case ({pos, neg})
            2'b10:   step = 2'sb01;
            2'b01:   step = 2'sb11;
            default: step = 2'sb00;
        endcase
        return step;
    endfunction

endpackage

// File: rtl/trackball_quadrature_quad_axis.sv
// One trackball axis: signed motion accumulator drained one count per tick into a
// clock/direction pair.
module quad_axis
    import trackball_pkg::*;
#(
    parameter int W = ACC_W_DEF
) (
    input  logic                clk_sys,
    input  logic                reset_n,
    input  logic signed [W-1:0] delta_i,
    input  logic signed [1:0]   joy_delta_i,
    input  logic                tick_i,
    output logic signed [W-1:0] acc_o,
    output logic                clk_o,
    output logic                dir_o
);

    localparam int LIMIT = (1 << (W - 1)) - 1;

    logic                  drain_en;
    logic signed [W+1:0]   drain;
    logic signed [W+1:0]   sum;
    logic signed [W-1:0]   acc_next;

    assign drain_en = tick_i && (acc_o != '0);

    // Sum all contributions with two guard bits, then clamp symmetrically
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        drain = '0;
        if (drain_en) begin
            drain = acc_o[W-1] ? (W+2)'(1) : -(W+2)'(1);
        end
        sum      = (W+2)'(acc_o) + (W+2)'(delta_i) + (W+2)'(joy_delta_i) + drain;
        acc_next = W'(sat(int'(sum), LIMIT));
    end

    // Accumulator and the clock/direction pair share one register stage
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: state is written with <= so every register samples pre-edge values.
            acc_o <= '0;
            clk_o <= 1'b0;
            dir_o <= 1'b0;
        end else begin
            acc_o <= acc_next;
            if (drain_en) begin
                dir_o <= !acc_o[W-1];
                clk_o <= !clk_o;
            end
        end
    end

endmodule

// File: rtl/trackball_quadrature.sv
// PS/2 mouse packets and joystick emulation to two-axis quadrature trackball signals.
module trackball_quadrature
    import trackball_pkg::*;
#(
    parameter int ACC_W      = ACC_W_DEF,
    parameter int STEP_DIV   = 64,
    parameter int JOY_PERIOD = 6000
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic [24:0] ps2_mouse,
    input  logic        flip,
    input  logic        joy_en,
    input  logic        joy_l,
    input  logic        joy_r,
    input  logic        joy_u,
    input  logic        joy_d,
    output logic [7:0]  trak_o,
    output logic        busy_o
);

    localparam int PRE_W = $clog2(STEP_DIV);
    localparam int JOY_W = $clog2(JOY_PERIOD);

    logic                    tog_q;
    logic                    armed_q;
    logic                    pkt;
    logic [PRE_W-1:0]        pre_q;
    logic                    tick;
    logic [JOY_W-1:0]        joy_cnt_q;
    logic                    joy_wrap;
    logic signed [ACC_W-1:0] dx_ext;
    logic signed [ACC_W-1:0] dy_ext;
    logic signed [ACC_W-1:0] dx_pkt;
    logic signed [ACC_W-1:0] dy_pkt;
    logic signed [1:0]       jx;
    logic signed [1:0]       jy;
    logic signed [ACC_W-1:0] acc_x;
    logic signed [ACC_W-1:0] acc_y;
    logic                    xclk;
    logic                    xdir;
    logic                    yclk;
    logic                    ydir;
    logic                    unused_ps2;

    assign unused_ps2 = &{1'b0, ps2_mouse[7:6], ps2_mouse[3:0]};

    // The first clock after reset only arms, so a toggle bit already set is not a packet
    assign pkt = armed_q && (ps2_mouse[TOG] != tog_q);

    // Packet toggle tracking and arm flag
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            tog_q   <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            tog_q   <= ps2_mouse[TOG];
            armed_q <= 1'b1;
        end
    end

    assign tick = (pre_q == PRE_W'(STEP_DIV - 1));

    // Drain-rate prescaler
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            pre_q <= '0;
        end else begin
            pre_q <= tick ? '0 : pre_q + PRE_W'(1);
        end
    end

    assign joy_wrap = joy_en && (joy_cnt_q == JOY_W'(JOY_PERIOD - 1));

    // Joystick repeat timer, parked at zero while joystick emulation is off
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            joy_cnt_q <= '0;
        end else if (!joy_en || joy_wrap) begin
            joy_cnt_q <= '0;
        end else begin
            joy_cnt_q <= joy_cnt_q + JOY_W'(1);
        end
    end

    // 9-bit packet deltas, sign-extended and optionally negated for cocktail flip
    assign dx_ext = ACC_W'($signed({ps2_mouse[XS], ps2_mouse[DX_MSB -: 8]}));
    assign dy_ext = ACC_W'($signed({ps2_mouse[YS], ps2_mouse[DY_MSB -: 8]}));

    // Gate the deltas onto the packet strobe and the joystick counts onto the timer wrap
    always_comb begin
        dx_pkt = '0;
        dy_pkt = '0;
        jx     = '0;
        jy     = '0;
        if (pkt) begin
            dx_pkt = flip ? -dx_ext : dx_ext;
            dy_pkt = flip ? -dy_ext : dy_ext;
        end
        if (joy_wrap) begin
            jx = joy_step(joy_r, joy_l);
            jy = joy_step(joy_u, joy_d);
        end
    end

    quad_axis #(.W(ACC_W)) u_axis_x (
        .clk_sys     (clk_sys),
        .reset_n     (reset_n),
        .delta_i     (dx_pkt),
        .joy_delta_i (jx),
        .tick_i      (tick),
        .acc_o       (acc_x),
        .clk_o       (xclk),
        .dir_o       (xdir)
    );

    quad_axis #(.W(ACC_W)) u_axis_y (
        .clk_sys     (clk_sys),
        .reset_n     (reset_n),
        .delta_i     (dy_pkt),
        .joy_delta_i (jy),
        .tick_i      (tick),
        .acc_o       (acc_y),
        .clk_o       (yclk),
        .dir_o       (ydir)
    );

    assign trak_o = {xdir, xdir, xclk, xclk, ydir, ydir, yclk, yclk};
    assign busy_o = (acc_x != '0) || (acc_y != '0);

endmodule

// File: tb/tb_trackball_quadrature.sv
// Directed bench for trackball_quadrature with a cycle-level behavioural model.
module tb_trackball_quadrature;

    localparam int STEP_DIV   = 64;
    localparam int JOY_PERIOD = 6000;
    localparam int LIMIT      = 2047;

    logic        clk_sys   = 1'b0;
    logic        reset_n   = 1'b0;
    logic [24:0] ps2_mouse = 25'h1000000;
    logic        flip      = 1'b0;
    logic        joy_en    = 1'b0;
    logic        joy_l     = 1'b0;
    logic        joy_r     = 1'b0;
    logic        joy_u     = 1'b0;
    logic        joy_d     = 1'b0;
    logic [7:0]  trak_o;
    logic        busy_o;

    int total = 0;
    int bad   = 0;

    trackball_quadrature #(
        .ACC_W      (12),
        .STEP_DIV   (STEP_DIV),
        .JOY_PERIOD (JOY_PERIOD)
    ) u_dut (
        .clk_sys   (clk_sys),
        .reset_n   (reset_n),
        .ps2_mouse (ps2_mouse),
        .flip      (flip),
        .joy_en    (joy_en),
        .joy_l     (joy_l),
        .joy_r     (joy_r),
        .joy_u     (joy_u),
        .joy_d     (joy_d),
        .trak_o    (trak_o),
        .busy_o    (busy_o)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, $signed(act), $signed(exp));
        end
    endtask

    // ---------------- behavioural model ----------------
    int m_accx = 0, m_accy = 0, m_pre = 0, m_jc = 0;
    bit m_armed = 0, m_tog = 0;
    bit m_xclk = 0, m_xdir = 0, m_yclk = 0, m_ydir = 0;

    function automatic int delta9(input bit s, input logic [7:0] d);
        return s ? int'(d) - 256 : int'(d);
    endfunction

    function automatic int clamp(input int v);
        return (v > LIMIT) ? LIMIT : (v < -LIMIT) ? -LIMIT : v;
    endfunction

    task automatic axis_step(inout int acc, inout bit c, inout bit d, input int add, input bit tick);
        int drain;
        drain = 0;
        if (tick && acc != 0) begin
            d     = (acc > 0);
            c     = !c;
            drain = (acc > 0) ? -1 : 1;
        end
        acc = clamp(acc + add + drain);
    endtask

    task automatic model_reset();
        m_accx = 0; m_accy = 0; m_pre = 0; m_jc = 0;
        m_armed = 0; m_tog = 0;
        m_xclk = 0; m_xdir = 0; m_yclk = 0; m_ydir = 0;
    endtask

    task automatic model_step();
        int dx, dy, jx, jy;
        bit pkt, tick, wrap;
        dx = 0; dy = 0; jx = 0; jy = 0; wrap = 0;
        pkt     = m_armed && (ps2_mouse[24] != m_tog);
        m_tog   = ps2_mouse[24];
        m_armed = 1;
        if (pkt) begin
            dx = delta9(ps2_mouse[4], ps2_mouse[15:8]);
            dy = delta9(ps2_mouse[5], ps2_mouse[23:16]);
            if (flip) begin
                dx = -dx;
                dy = -dy;
            end
        end
        tick  = (m_pre == STEP_DIV - 1);
        m_pre = (m_pre + 1) % STEP_DIV;
        if (joy_en) begin
            wrap = (m_jc == JOY_PERIOD - 1);
            m_jc = (m_jc + 1) % JOY_PERIOD;
        end else begin
            m_jc = 0;
        end
        if (wrap) begin
            jx = int'(joy_r) - int'(joy_l);
            jy = int'(joy_u) - int'(joy_d);
        end
        axis_step(m_accx, m_xclk, m_xdir, dx + jx, tick);
        axis_step(m_accy, m_yclk, m_ydir, dy + jy, tick);
    endtask

    initial forever begin
        @(posedge clk_sys or negedge reset_n);
        if (!reset_n) model_reset();
        else          model_step();
    end

    // Every-cycle comparison against the model
    initial forever begin
        @(negedge clk_sys);
        check("trak_o", 32'(trak_o),
              32'({m_xdir, m_xdir, m_xclk, m_xclk, m_ydir, m_ydir, m_yclk, m_yclk}));
        check("busy_o", 32'(busy_o), 32'(m_accx != 0 || m_accy != 0));
    end

    // ---------------- X edge log ----------------
    int   cyc = 0;
    logic prev_xclk = 1'b0;
    int   edge_cycle[$];
    bit   edge_dir[$];
    bit   edge_busy[$];

    initial forever begin
        @(negedge clk_sys);
        cyc++;
        if (!reset_n) begin
            prev_xclk = 1'b0;
        end else begin
            if (trak_o[5] !== prev_xclk) begin
                edge_cycle.push_back(cyc);
                edge_dir.push_back(trak_o[7]);
                edge_busy.push_back(busy_o);
            end
            prev_xclk = trak_o[5];
        end
    end

    task automatic clear_log();
        edge_cycle.delete();
        edge_dir.delete();
        edge_busy.delete();
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic cycles(input int n);
        repeat (n) @(negedge clk_sys);
    endtask

    task automatic send_pkt(input bit xs, input logic [7:0] dx, input bit ys, input logic [7:0] dy);
        ps2_mouse[15:8]  = dx;
        ps2_mouse[4]     = xs;
        ps2_mouse[23:16] = dy;
        ps2_mouse[5]     = ys;
        ps2_mouse[24]    = ~ps2_mouse[24];
        @(negedge clk_sys);
    endtask

    task automatic do_reset();
        @(posedge clk_sys);
        #2 reset_n = 1'b0;
        @(negedge clk_sys);
        @(negedge clk_sys);
        reset_n = 1'b1;
    endtask

    // Wait (bounded) until the coming edge has the given prescaler phase
    task automatic wait_pre(input int target);
        int n;
        n = 0;
        while (m_pre != target && n < 2 * STEP_DIV) begin
            @(negedge clk_sys);
            n++;
        end
    endtask

    initial begin
        cycles(3);
        reset_n = 1'b1;

        // 1: toggle bit high through reset is not a packet
        cycles(200);
        check("t1_trak", 32'(trak_o), 32'h00);
        check("t1_busy", 32'(busy_o), 32'd0);
        check("t1_accx", 32'(int'(u_dut.u_axis_x.acc_o)), 32'd0);
        check("t1_edges", 32'(edge_cycle.size()), 32'd0);

        // 2: dx=+5 -> five edges, dir 1, 64 cycles apart, busy drops on the fifth
        clear_log();
        send_pkt(0, 8'h05, 0, 8'h00);
        cycles(6 * STEP_DIV);
        check("t2_edges", 32'(edge_cycle.size()), 32'd5);
        if (edge_cycle.size() == 5) begin
            for (int i = 0; i < 5; i++) check("t2_dir", 32'(edge_dir[i]), 32'd1);
            for (int i = 1; i < 5; i++)
                check("t2_spacing", 32'(edge_cycle[i] - edge_cycle[i-1]), 32'(STEP_DIV));
            check("t2_busy_4th", 32'(edge_busy[3]), 32'd1);
            check("t2_busy_5th", 32'(edge_busy[4]), 32'd0);
        end
        check("t2_trak", 32'(trak_o), 32'hF0);

        // 3: -3 with flip -> +3 (dir 1); without flip -> dir 0
        flip = 1'b1;
        clear_log();
        send_pkt(1, 8'hFD, 0, 8'h00);
        cycles(5 * STEP_DIV);
        check("t3_flip_edges", 32'(edge_cycle.size()), 32'd3);
        foreach (edge_dir[i]) check("t3_flip_dir", 32'(edge_dir[i]), 32'd1);
        flip = 1'b0;
        clear_log();
        send_pkt(1, 8'hFD, 0, 8'h00);
        cycles(5 * STEP_DIV);
        check("t3_noflip_edges", 32'(edge_cycle.size()), 32'd3);
        foreach (edge_dir[i]) check("t3_noflip_dir", 32'(edge_dir[i]), 32'd0);
        check("t3_trak", 32'(trak_o), 32'h30);

        // 4: nine +255 packets back-to-back saturate at +2047
        do_reset();
        wait_pre(2);
        repeat (9) send_pkt(0, 8'hFF, 0, 8'h00);
        check("t4_accx", 32'(int'(u_dut.u_axis_x.acc_o)), 32'd2047);
        check("t4_model_accx", 32'(m_accx), 32'd2047);
        check("t4_busy", 32'(busy_o), 32'd1);

        // 5: acc=+2, dx=-4 landing on a tick -> -3, edge dirs 1,0,0,0
        do_reset();
        wait_pre(5);
        send_pkt(0, 8'h02, 0, 8'h00);
        check("t5_acc_pre", 32'(int'(u_dut.u_axis_x.acc_o)), 32'd2);
        wait_pre(STEP_DIV - 1);
        clear_log();
        send_pkt(1, 8'hFC, 0, 8'h00);
        check("t5_acc_post", 32'(int'(u_dut.u_axis_x.acc_o)), -32'sd3);
        cycles(5 * STEP_DIV);
        check("t5_edges", 32'(edge_cycle.size()), 32'd4);
        if (edge_dir.size() == 4) begin
            check("t5_dir0", 32'(edge_dir[0]), 32'd1);
            for (int i = 1; i < 4; i++) check("t5_dir_rev", 32'(edge_dir[i]), 32'd0);
        end

        // 6: joystick right for three periods, opposing pair, reset mid-drain
        do_reset();
        clear_log();
        joy_en = 1'b1;
        joy_r  = 1'b1;
        cycles(3 * JOY_PERIOD + 5);
        joy_r = 1'b0;
        cycles(100);
        check("t6_joy_edges", 32'(edge_cycle.size()), 32'd3);
        foreach (edge_dir[i]) check("t6_joy_dir", 32'(edge_dir[i]), 32'd1);
        clear_log();
        joy_l = 1'b1;
        joy_r = 1'b1;
        cycles(JOY_PERIOD + 100);
        check("t6_opposed_edges", 32'(edge_cycle.size()), 32'd0);
        joy_l  = 1'b0;
        joy_r  = 1'b0;
        joy_en = 1'b0;
        send_pkt(0, 8'd100, 0, 8'h00);
        cycles(200);
        check("t6_pre_dir", 32'(trak_o[7]), 32'd1);
        check("t6_pre_busy", 32'(busy_o), 32'd1);
        @(posedge clk_sys);
        #2 reset_n = 1'b0;
        #1;
        check("t6_rst_trak", 32'(trak_o), 32'h00);
        check("t6_rst_busy", 32'(busy_o), 32'd0);
        @(negedge clk_sys);
        reset_n = 1'b1;
        cycles(5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
